// File: rtl/ques_four.sv
// ============================================================================
// ques_four
// ----------------------------------------------------------------------------
// Registered 8-to-3 priority encoder with an active-input count flag.
// Eight request lines D7..D0 (D7 highest priority) are encoded into the
// 3-bit index of the highest-numbered asserted line. All outputs are
// registered, so results appear one clock after the inputs are sampled and
// there is no combinational path from inputs to outputs.
//
// Ports
//   clk    in   1  system clock, rising-edge active
//   rst    in   1  synchronous, active-high reset (overrides all inputs)
//   D7..D0 in   1  request lines, D7 highest priority, D0 lowest
//   Y      out  3  index of highest asserted line (000 when none asserted)
//   valid  out  1  at least one request line was asserted
//   multi  out  1  two or more request lines were asserted
// ============================================================================
module ques_four (
    input  logic       D7,
    input  logic       D6,
    input  logic       D5,
    input  logic       D4,
    input  logic       D3,
    input  logic       D2,
    input  logic       D1,
    input  logic       D0,
    output logic [2:0] Y,
    input  logic       clk,
    input  logic       rst,
    output logic       valid,
    output logic       multi
);

    logic [7:0] w_req;
    logic [2:0] w_idx;
    logic [3:0] w_count;
    logic [2:0] r_y;
    logic       r_valid;
    logic       r_multi;

    assign w_req = {D7, D6, D5, D4, D3, D2, D1, D0};

    // Ascending scan where the last hit wins yields the highest asserted
    // index. Plain if-tests keep the result defined for every 0/1 pattern,
    // unlike casez wildcards. The same scan accumulates the population count.
    always_comb begin
        w_idx   = 3'd0;
        w_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_req[i]) begin
                w_idx   = 3'(i);
                w_count = w_count + 4'd1;
            end
        end
    end

    // Output registers: reset forces the idle values, otherwise every edge
    // captures the current encoding so outputs hold while inputs are stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= 3'd0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            r_y     <= w_idx;
            r_valid <= (w_count != 4'd0);
            r_multi <= (w_count >= 4'd2);
        end
    end

    assign Y     = r_y;
    assign valid = r_valid;
    assign multi = r_multi;

endmodule

// File: tb/tb_ques_four.sv
// ============================================================================
// tb_ques_four
// ----------------------------------------------------------------------------
// Self-checking bench for ques_four. Directed scenarios followed by random
// vectors, each compared against a behavioural model of the encoder.
// ============================================================================
module tb_ques_four;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [2:0] Y;
    logic       valid;
    logic       multi;

    int errors = 0;
    int checks = 0;

    ques_four dut (
        .D7    (d[7]),
        .D6    (d[6]),
        .D5    (d[5]),
        .D4    (d[4]),
        .D3    (d[3]),
        .D2    (d[2]),
        .D1    (d[1]),
        .D0    (d[0]),
        .Y     (Y),
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: highest set index found by a downward search.
    function automatic logic [2:0] modelY(input logic [7:0] v, input logic r);
        if (r) return 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic modelValid(input logic [7:0] v, input logic r);
        return !r && ($countones(v) > 0);
    endfunction

    function automatic logic modelMulti(input logic [7:0] v, input logic r);
        return !r && ($countones(v) > 1);
    endfunction

    // Drive inputs just after an edge, then step one clock so the result is
    // sampled 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [7:0] v, input logic r);
        d   = v;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] v, input logic r);
        logic [2:0] expY;
        logic       expV;
        logic       expM;
        expY = modelY(v, r);
        expV = modelValid(v, r);
        expM = modelMulti(v, r);
        checks++;
        assert (Y === expY) else begin
            errors++;
            $error("[TB] FAIL %s Y: got %b expected %b (d=%b rst=%b)", tag, Y, expY, v, r);
        end
        checks++;
        assert (valid === expV) else begin
            errors++;
            $error("[TB] FAIL %s valid: got %b expected %b (d=%b rst=%b)", tag, valid, expV, v, r);
        end
        checks++;
        assert (multi === expM) else begin
            errors++;
            $error("[TB] FAIL %s multi: got %b expected %b (d=%b rst=%b)", tag, multi, expM, v, r);
        end
    endtask

    initial begin
        logic [7:0] v;
        logic       r;

        d   = 8'h00;
        rst = 1'b1;
        #2;

        // Reset with random data on the request lines
        for (int i = 0; i < 2; i++) begin
            v = 8'($urandom);
            applyStimulus(v, 1'b1);
            checkOutput("reset", v, 1'b1);
        end

        // One-hot walk D0..D7
        for (int i = 0; i < 8; i++) begin
            v = 8'h01 << i;
            applyStimulus(v, 1'b0);
            checkOutput("onehot", v, 1'b0);
        end

        // Strict priority with multiple requests
        applyStimulus(8'b1010_0000, 1'b0);
        checkOutput("d7d5", 8'b1010_0000, 1'b0);
        applyStimulus(8'b0010_0001, 1'b0);
        checkOutput("d5d0", 8'b0010_0001, 1'b0);

        // Idle after activity, then hold
        applyStimulus(8'h00, 1'b0);
        checkOutput("idle", 8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("idleHold", 8'h00, 1'b0);

        // All requests, then drop D7
        applyStimulus(8'hFF, 1'b0);
        checkOutput("allOnes", 8'hFF, 1'b0);
        applyStimulus(8'h7F, 1'b0);
        checkOutput("dropD7", 8'h7F, 1'b0);

        // Reset in the middle of a one-hot walk
        for (int i = 0; i < 4; i++) begin
            v = 8'h01 << i;
            applyStimulus(v, 1'b0);
            checkOutput("walkPre", v, 1'b0);
        end
        applyStimulus(8'h10, 1'b1);
        checkOutput("midReset", 8'h10, 1'b1);
        applyStimulus(8'h10, 1'b0);
        checkOutput("postReset", 8'h10, 1'b0);
        applyStimulus(8'h10, 1'b0);
        checkOutput("postHold", 8'h10, 1'b0);

        // Random vectors with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v = v & 8'($urandom);
            r = ($urandom_range(0, 19) == 0);
            applyStimulus(v, r);
            checkOutput("random", v, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
